// File: rtl/plm_bank.sv
//------------------------------------------------------------------------------
// plm_bank: multi-port private local memory bank, cleared by an INIT sweep after reset.
// Optional macro PLM_FWD_EN: write-first forwarding for same-cycle read/write collisions.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module plm_bank #(
  parameter int ADDR_WIDTH  = 10,
  parameter int VALUE_WIDTH = 8,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2,
  localparam int PLM_ADDR_WIDTH  = ADDR_WIDTH - $clog2(NBANKS),
  localparam int PLM_DEPTH       = 2 ** PLM_ADDR_WIDTH,
  localparam int PLM_INPUT_WIDTH = PLM_ADDR_WIDTH + VALUE_WIDTH + 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NPORTS-1:0][PLM_INPUT_WIDTH-1:0]        plm_inputs,
  output logic [NPORTS-1:0][VALUE_WIDTH-1:0]            rdata,
  output logic [NPORTS-1:0]                             rdata_valid,
  output logic                                          ready,
  output logic                                          wr_conflict
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                                   state;
  state_t                                   state_next;
  logic [PLM_ADDR_WIDTH-1:0]                init_cnt;
  logic [PLM_ADDR_WIDTH-1:0]                init_cnt_next;
  logic [VALUE_WIDTH-1:0]                   mem [PLM_DEPTH];

  logic [NPORTS-1:0][PLM_ADDR_WIDTH-1:0]    port_addr;
  logic [NPORTS-1:0][VALUE_WIDTH-1:0]       port_value;
  logic [NPORTS-1:0]                        port_wr;
  logic [NPORTS-1:0][VALUE_WIDTH-1:0]       read_val;
  logic                                     conflict_next;

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
      assign port_addr[p]  = plm_inputs[p][PLM_INPUT_WIDTH-1 -: PLM_ADDR_WIDTH];
      assign port_value[p] = plm_inputs[p][VALUE_WIDTH:1];
      assign port_wr[p]    = plm_inputs[p][0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    case (state)
      INIT: begin
        init_cnt_next = init_cnt + 1'b1;
        if (init_cnt == PLM_ADDR_WIDTH'(PLM_DEPTH - 1)) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign ready = (state == RUN);

  // Later ports are applied last, so the highest-numbered writer wins a collision.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (port_wr[p]) mem[port_addr[p]] <= port_value[p];
      end
    end
  end

`ifdef PLM_FWD_EN
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      read_val[p] = mem[port_addr[p]];
      for (int q = 0; q < NPORTS; q++) begin
        if (port_wr[q] && (port_addr[q] == port_addr[p])) read_val[p] = port_value[q];
      end
    end
  end
`else
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      read_val[p] = mem[port_addr[p]];
    end
  end
`endif

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = i + 1; j < NPORTS; j++) begin
        if (port_wr[i] && port_wr[j] && (port_addr[i] == port_addr[j])) conflict_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata       <= '0;
      rdata_valid <= '0;
      wr_conflict <= 1'b0;
    end else if (state == RUN) begin
      wr_conflict <= conflict_next;
      for (int p = 0; p < NPORTS; p++) begin
        if (port_wr[p]) begin
          rdata_valid[p] <= 1'b0;
        end else begin
          rdata[p]       <= read_val[p];
          rdata_valid[p] <= 1'b1;
        end
      end
    end else begin
      rdata_valid <= '0;
      wr_conflict <= 1'b0;
    end
  end

endmodule

`default_nettype wire
